// File: rtl/pager_pkg.sv
// pager_pkg: shared state encoding and default timing constants for the page sender
package pager_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ZERO  = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam int DEF_BIT_CYCLES = 4;
    localparam int DEF_ZERO_BITS  = 3;
    localparam int DEF_GUARD_BITS = 2;

endpackage

// File: rtl/pager_bit_timer.sv
// pager_bit_timer: bit-period prescaler, pulses tick on the last clk cycle of each bit period
module pager_bit_timer
    import pager_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(BIT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(BIT_CYCLES - 1);

    // cycle counter wraps after BIT_CYCLES-1; clear realigns the bit period to a page start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/page_sender.sv
// page_sender: emits rpt+1 low bursts on x_out, each followed by a high guard interval
module page_sender
    import pager_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int ZERO_BITS  = DEF_ZERO_BITS,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] rpt,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       x_out
);

    localparam int MAX_BITS = ZERO_BITS > GUARD_BITS ? ZERO_BITS : GUARD_BITS;
    localparam int BW       = $clog2(MAX_BITS + 1);

    state_t        state, state_n;
    logic [BW-1:0] bits, bits_n;
    logic [1:0]    rem, rem_n;
    logic          ack_n, busy_n, done_n, x_n;
    logic          clear, tick, last;

    pager_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    // final bit tick of the current ZERO or GUARD interval
    always_comb begin
        last = tick && bits == (state == ZERO ? BW'(ZERO_BITS - 1) : BW'(GUARD_BITS - 1));
    end

    // next-state, counter and registered-output decisions
    always_comb begin
        state_n = state;
        bits_n  = tick ? (last ? '0 : bits + BW'(1)) : bits;
        rem_n   = rem;
        ack_n   = 1'b0;
        done_n  = 1'b0;
        busy_n  = busy;
        x_n     = x_out;
        clear   = 1'b0;
        case (state)
            IDLE: begin
                bits_n = '0;
                if (req) begin
                    state_n = ZERO;
                    rem_n   = rpt;
                    ack_n   = 1'b1;
                    busy_n  = 1'b1;
                    x_n     = 1'b0;
                    clear   = 1'b1;
                end
            end
            ZERO: begin
                if (last) begin
                    state_n = GUARD;
                    x_n     = 1'b1;
                end
            end
            GUARD: begin
                if (last) begin
                    if (rem != 2'd0) begin
                        state_n = ZERO;
                        rem_n   = rem - 2'd1;
                        x_n     = 1'b0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                x_n     = 1'b1;
            end
        endcase
    end

    // state, counters and outputs; reset drops any page in progress without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bits  <= '0;
            rem   <= '0;
            ack   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            x_out <= 1'b1;
        end else begin
            state <= state_n;
            bits  <= bits_n;
            rem   <= rem_n;
            ack   <= ack_n;
            busy  <= busy_n;
            done  <= done_n;
            x_out <= x_n;
        end
    end

endmodule

// File: tb/tb_page_sender.sv
// tb_page_sender: directed scoreboard bench for page_sender at default timing
module tb_page_sender;

    localparam int LOW  = 12;
    localparam int HIGH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] rpt;
    logic       ack, busy, done, x_out;

    logic [3:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    page_sender dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .rpt   (rpt),
        .ack   (ack),
        .busy  (busy),
        .done  (done),
        .x_out (x_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s {ack,busy,done,x_out} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(4'b0001);
    endtask

    task automatic push_page(input int bursts);
        for (int k = 0; k < bursts * (LOW + HIGH); k++)
            exp_q.push_back({k == 0, 1'b1, 1'b0, (k % (LOW + HIGH)) >= LOW});
        exp_q.push_back(4'b0011);
    endtask

    task automatic step(input string tag, input logic r, input logic [1:0] p);
        req = r;
        rpt = p;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=%b expected=none", tag, {ack, busy, done, x_out});
        end else begin
            check(tag, {ack, busy, done, x_out}, exp_q.pop_front());
        end
    endtask

    task automatic drain(input string tag, input logic r, input logic [1:0] p);
        while (exp_q.size() > 0) step(tag, r, p);
    endtask

    initial begin
        req = 1'b0;
        rpt = 2'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset", {ack, busy, done, x_out}, 4'b0001);
        @(negedge clk) rst = 1'b0;
        push_idle(2);
        drain("idle", 1'b0, 2'd0);

        push_page(1);
        step("single", 1'b1, 2'd0);
        drain("single", 1'b0, 2'd0);
        push_idle(1);
        drain("single_idle", 1'b0, 2'd0);

        push_page(1);
        step("ignore", 1'b1, 2'd0);
        repeat (4) step("ignore", 1'b0, 2'd0);
        step("ignore", 1'b1, 2'd3);
        step("ignore", 1'b0, 2'd3);
        step("ignore", 1'b1, 2'd3);
        drain("ignore", 1'b0, 2'd0);
        push_idle(1);
        drain("ignore_idle", 1'b0, 2'd0);

        push_page(3);
        step("repeat", 1'b1, 2'd2);
        drain("repeat", 1'b0, 2'd0);
        push_idle(1);
        drain("repeat_idle", 1'b0, 2'd0);

        push_page(1);
        push_page(1);
        while (exp_q.size() > 1) step("b2b", 1'b1, 2'd0);
        step("b2b", 1'b0, 2'd0);
        push_idle(2);
        drain("b2b_idle", 1'b0, 2'd0);

        for (int k = 0; k < 6; k++) exp_q.push_back({k == 0, 1'b1, 1'b0, 1'b0});
        step("abort", 1'b1, 2'd0);
        drain("abort", 1'b0, 2'd0);
        #2 rst = 1'b1;
        #1 check("abort_async", {ack, busy, done, x_out}, 4'b0001);
        @(negedge clk) rst = 1'b0;
        push_idle(3);
        drain("abort_idle", 1'b0, 2'd0);

        push_page(1);
        step("fresh", 1'b1, 2'd0);
        drain("fresh", 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
